// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks one M-stage exception by fixed priority, updates cp0,
// flushes the pipeline and holds a PC redirect to fetch until the PC unit accepts it.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m_i,
  input  logic [31:0] pc_m_i,
  input  logic        delayslot_m_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        sys_i,
  input  logic        bp_i,
  input  logic        ov_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic        eret_i,
  input  logic [31:0] data_addr_i,
  input  logic [5:0]  hw_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        cp0_en_o,
  output logic [31:0] except_type_o,
  output logic [31:0] badvaddr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        stall_o
);

  localparam logic [31:0] TypeInt  = 32'h1;
  localparam logic [31:0] TypeAdel = 32'h4;
  localparam logic [31:0] TypeAdes = 32'h5;
  localparam logic [31:0] TypeSys  = 32'h8;
  localparam logic [31:0] TypeBp   = 32'h9;
  localparam logic [31:0] TypeRi   = 32'hA;
  localparam logic [31:0] TypeOv   = 32'hC;
  localparam logic [31:0] TypeEret = 32'hE;

  typedef enum logic [0:0] {StIdle, StRedir} state_e;

  state_e      state_q, state_d;
  logic [31:0] redirect_pc_q;
  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [5:0]  hw_sync;
  logic [7:0]  ip;
  logic        int_pend;
  logic [31:0] exc_type;
  logic [31:0] exc_badv;
  logic [31:0] exc_target;
  logic        unused_bits;

  assign unused_bits = ^{delayslot_m_i, status_i[31:16], status_i[7:2], cause_i[31],
                         cause_i[29:10], cause_i[7:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= hw_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_sync  = sync_q[SYNC_STAGES-1];
  assign ip       = {hw_sync[5] | cause_i[30], hw_sync[4:0], cause_i[9:8]};
  assign int_pend = (|(ip & status_i[15:8])) & status_i[0] & ~status_i[1];

  // Priority select; evaluation is suppressed in reset, while redirecting, or on a bubble.
  always_comb begin
    exc_type = '0;
    exc_badv = '0;
    if (rst && state_q == StIdle && valid_m_i) begin
      if (int_pend) begin
        exc_type = TypeInt;
      end else if (adel_if_i) begin
        exc_type = TypeAdel;
        exc_badv = pc_m_i;
      end else if (ri_i) begin
        exc_type = TypeRi;
      end else if (sys_i) begin
        exc_type = TypeSys;
      end else if (bp_i) begin
        exc_type = TypeBp;
      end else if (ov_i) begin
        exc_type = TypeOv;
      end else if (adel_ld_i) begin
        exc_type = TypeAdel;
        exc_badv = data_addr_i;
      end else if (ades_st_i) begin
        exc_type = TypeAdes;
        exc_badv = data_addr_i;
      end else if (eret_i) begin
        exc_type = TypeEret;
      end
    end
  end

  assign exc_target = (exc_type == TypeEret) ? epc_i : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && exc_type != '0) redirect_pc_q <= exc_target;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (exc_type != '0) state_d = StRedir;
      StRedir: if (redirect_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    except_type_o    = exc_type;
    badvaddr_o       = exc_badv;
    cp0_en_o         = (exc_type != '0);
    flush_o          = (exc_type != '0);
    redirect_valid_o = (state_q == StRedir);
    stall_o          = (state_q == StRedir);
    redirect_pc_o    = redirect_pc_q;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, hand sequences for the multi-cycle
// corners, then randomized traffic against a priority-list reference model.
module tb_exc_ctrl;

  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam logic [31:0] PRIO_CODES [9] = '{32'h1, 32'h4, 32'hA, 32'h8, 32'h9, 32'hC, 32'h4,
                                            32'h5, 32'hE};

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, delayslot_m, adel_if, ri, sys, bp, ov, adel_ld, ades_st, eret;
  logic [31:0] pc_m, data_addr, status, cause, epc;
  logic [5:0]  hw_int;
  logic        ready;
  logic        cp0_en, flush, redirect_valid, stall;
  logic [31:0] except_type, badvaddr, redirect_pc;

  int passed = 0;
  int total  = 0;

  // Reference model state: outstanding redirect, its target, and hw_int as sampled at past edges.
  logic        m_busy;
  logic [31:0] m_pc;
  logic [5:0]  hist [2];

  exc_ctrl #(.EXC_VECTOR(EXC), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .valid_m_i(valid_m), .pc_m_i(pc_m), .delayslot_m_i(delayslot_m),
    .adel_if_i(adel_if), .ri_i(ri), .sys_i(sys), .bp_i(bp), .ov_i(ov), .adel_ld_i(adel_ld),
    .ades_st_i(ades_st), .eret_i(eret), .data_addr_i(data_addr), .hw_int_i(hw_int),
    .status_i(status), .cause_i(cause), .epc_i(epc), .cp0_en_o(cp0_en),
    .except_type_o(except_type), .badvaddr_o(badvaddr), .flush_o(flush),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
    .redirect_ready_i(ready), .stall_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  flags;  // {adel_if, ri, sys, bp, ov, adel_ld, ades, eret}
    logic [31:0] pc, daddr, epc, status, cause, typ, badv, target;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive_flags(input logic [7:0] f);
    {adel_if, ri, sys, bp, ov, adel_ld, ades_st, eret} = f;
  endtask

  function automatic void model_eval(output logic [31:0] t, output logic [31:0] bv);
    logic [7:0] ip;
    logic       pend;
    logic [8:0] req;
    t  = '0;
    bv = '0;
    if (!rst || m_busy || !valid_m) return;
    ip   = {hist[1][5] | cause[30], hist[1][4:0], cause[9:8]};
    pend = (|(ip & status[15:8])) && status[0] && !status[1];
    req  = {pend, adel_if, ri, sys, bp, ov, adel_ld, ades_st, eret};
    for (int i = 0; i < 9; i++) begin
      if (req[8-i]) begin
        t  = PRIO_CODES[i];
        bv = (i == 1) ? pc_m : ((i == 6 || i == 7) ? data_addr : 32'h0);
        break;
      end
    end
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    @(negedge clk);
    valid_m = 1'b1; drive_flags(v.flags); pc_m = v.pc; data_addr = v.daddr;
    epc = v.epc; status = v.status; cause = v.cause; ready = 1'b0;
    #1;
    chk($sformatf("v%0d type", n), except_type, v.typ);
    chk($sformatf("v%0d badv", n), badvaddr, v.badv);
    chk($sformatf("v%0d cp0_en", n), {31'b0, cp0_en}, 32'h1);
    chk($sformatf("v%0d flush", n), {31'b0, flush}, 32'h1);
    @(negedge clk); #1;
    chk($sformatf("v%0d rvalid", n), {31'b0, redirect_valid}, 32'h1);
    chk($sformatf("v%0d rpc", n), redirect_pc, v.target);
    chk($sformatf("v%0d stall", n), {31'b0, stall}, 32'h1);
    chk($sformatf("v%0d no cp0_en in redir", n), {31'b0, cp0_en}, 32'h0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; valid_m = 1'b0; drive_flags(8'h0);
    #1;
    chk($sformatf("v%0d rvalid drop", n), {31'b0, redirect_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] t, bv;
    vecs[0] = '{8'h08, 32'h80001000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC, 32'h0, EXC};
    vecs[1] = '{8'h64, 32'h80001004, 32'h80000013, 32'h0, 32'h0, 32'h0, 32'hA, 32'h0, EXC};
    vecs[2] = '{8'h04, 32'h80001008, 32'h80000013, 32'h0, 32'h0, 32'h0, 32'h4, 32'h80000013,
                EXC};
    vecs[3] = '{8'h01, 32'h8000100C, 32'h0, 32'h80002004, 32'h0, 32'h0, 32'hE, 32'h0,
                32'h80002004};
    vecs[4] = '{8'h02, 32'h80001010, 32'h80000022, 32'h0, 32'h0, 32'h0, 32'h5, 32'h80000022,
                EXC};
    vecs[5] = '{8'h88, 32'h80000001, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h4, 32'h80000001,
                EXC};
    vecs[6] = '{8'h30, 32'h80001014, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'h0, EXC};
    vecs[7] = '{8'h18, 32'h80001018, 32'h0, 32'h0, 32'h0, 32'h0, 32'h9, 32'h0, EXC};
    vecs[8] = '{8'h01, 32'h8000101C, 32'h0, 32'h80003000, 32'h101, 32'h100, 32'h1, 32'h0, EXC};
    vecs[9] = '{8'h06, 32'h80001020, 32'h80000031, 32'h0, 32'h0, 32'h0, 32'h4, 32'h80000031,
                EXC};

    // Reset with an exception presented: combinational outputs must stay quiet.
    rst = 1'b0; valid_m = 1'b1; drive_flags(8'h08); pc_m = 32'h80001000; data_addr = '0;
    delayslot_m = 1'b0; hw_int = '0; status = '0; cause = '0; epc = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst rvalid", {31'b0, redirect_valid}, 32'h0);
    chk("rst rpc", redirect_pc, 32'h0);
    chk("rst stall", {31'b0, stall}, 32'h0);
    chk("rst cp0_en", {31'b0, cp0_en}, 32'h0);
    chk("rst type", except_type, 32'h0);
    rst = 1'b1; valid_m = 1'b0; drive_flags(8'h0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Redirect held while ready stays low.
    @(negedge clk);
    valid_m = 1'b1; drive_flags(8'h04); data_addr = 32'h80000013; status = '0; cause = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold%0d rvalid", i), {31'b0, redirect_valid}, 32'h1);
      chk($sformatf("hold%0d rpc", i), redirect_pc, EXC);
      chk($sformatf("hold%0d stall", i), {31'b0, stall}, 32'h1);
      chk($sformatf("hold%0d cp0_en", i), {31'b0, cp0_en}, 32'h0);
      @(negedge clk);
    end
    ready = 1'b1; valid_m = 1'b0; drive_flags(8'h0);
    @(negedge clk); ready = 1'b0; #1;
    chk("hold release", {31'b0, redirect_valid}, 32'h0);

    // hw_int[2] through the synchronizer; bubble defers, EXL masks.
    status = 32'h0000_1001; hw_int = 6'h04; valid_m = 1'b0;
    #1 chk("int bubble", except_type, 32'h0);
    @(negedge clk); valid_m = 1'b1; #1;
    chk("int sync1", except_type, 32'h0);
    @(negedge clk); #1;
    chk("int sync2 type", except_type, 32'h1);
    chk("int sync2 cp0_en", {31'b0, cp0_en}, 32'h1);
    @(negedge clk); #1;
    chk("int rpc", redirect_pc, EXC);
    ready = 1'b1;
    @(negedge clk); ready = 1'b0; status = 32'h0000_1003; #1;
    chk("int exl masked", except_type, 32'h0);
    hw_int = '0; valid_m = 1'b0; status = '0;

    // Reset while a redirect is outstanding.
    @(negedge clk); valid_m = 1'b1; drive_flags(8'h08);
    @(negedge clk); #1;
    chk("rr pre rvalid", {31'b0, redirect_valid}, 32'h1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rr rvalid", {31'b0, redirect_valid}, 32'h0);
    chk("rr stall", {31'b0, stall}, 32'h0);
    chk("rr rpc", redirect_pc, 32'h0);
    chk("rr cp0_en", {31'b0, cp0_en}, 32'h0);
    rst = 1'b1; #1;
    chk("rr idle accepts", except_type, 32'hC);
    ready = 1'b1;
    @(negedge clk); valid_m = 1'b0; drive_flags(8'h0);
    @(negedge clk); ready = 1'b0;

    // Known starting point for the model, then randomized traffic.
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_busy = 1'b0; m_pc = '0; hist[0] = '0; hist[1] = '0;
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) != 0);
      valid_m     = ($urandom_range(0, 3) != 0);
      delayslot_m = 1'(($urandom));
      drive_flags({8{1'b0}} | {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
      pc_m = $urandom; data_addr = $urandom; epc = $urandom; cause = $urandom;
      hw_int = 6'($urandom) & 6'($urandom) & 6'($urandom);
      status = $urandom;
      status[0] = ($urandom_range(0, 3) != 0);
      status[1] = ($urandom_range(0, 3) == 0);
      ready = 1'(($urandom));
      #1;
      model_eval(t, bv);
      chk("rnd type", except_type, t);
      chk("rnd badv", badvaddr, bv);
      chk("rnd cp0_en", {31'b0, cp0_en}, {31'b0, t != 0});
      chk("rnd flush", {31'b0, flush}, {31'b0, t != 0});
      chk("rnd rvalid", {31'b0, redirect_valid}, {31'b0, m_busy});
      chk("rnd stall", {31'b0, stall}, {31'b0, m_busy});
      chk("rnd rpc", redirect_pc, m_pc);
      if (!rst) begin
        m_busy = 1'b0; m_pc = '0; hist[0] = '0; hist[1] = '0;
      end else begin
        if (m_busy) begin
          if (ready) m_busy = 1'b0;
        end else if (t != 0) begin
          m_busy = 1'b1;
          m_pc   = (t == 32'hE) ? epc : EXC;
        end
        hist[1] = hist[0];
        hist[0] = hw_int;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
